// File: rtl/demux1_2_4bit_buf.sv
// Buffered 1-to-2 demultiplexer for 4-bit words.
// One valid/ready input stream is steered by `s` (1 = channel 1, 0 = channel 2)
// into one of two independent 2-entry FIFOs, each drained by its own
// valid/ready consumer. Index 0 of every per-channel vector is channel 1
// (out1), index 1 is channel 2 (out2).
module demux1_2_4bit_buf (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in,
    input  logic       in_valid,
    input  logic       s,
    output logic       in_ready,
    output logic [3:0] out1,
    output logic       out1_valid,
    input  logic       out1_ready,
    output logic [3:0] out2,
    output logic       out2_valid,
    input  logic       out2_ready
);

    // Per-channel FIFO state: [channel][entry] storage, 1-bit pointers, 0..2 count
    logic [1:0][1:0][3:0] mem_q, mem_d;
    logic [1:0]           wp_q, wp_d;
    logic [1:0]           rp_q, rp_d;
    logic [1:0][1:0]      cnt_q, cnt_d;

    logic [1:0] sel_oh;
    logic [1:0] out_ready;
    logic [1:0] out_valid;
    logic [1:0] push;
    logic [1:0] pop;

    // Handshake decode: in_ready looks only at s and the registered counts, so a
    // full channel refuses a word even on a cycle where its consumer pops.
    always_comb begin
        sel_oh    = {~s, s};
        out_ready = {out2_ready, out1_ready};
        out_valid = {(cnt_q[1] != 2'd0), (cnt_q[0] != 2'd0)};
        in_ready  = s ? (cnt_q[0] != 2'd2) : (cnt_q[1] != 2'd2);
        push      = {2{in_valid & in_ready}} & sel_oh;
        pop       = out_valid & out_ready;
    end

    // Next-state for both FIFOs; a simultaneous push and pop leaves count unchanged.
    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        for (int ch = 0; ch < 2; ch++) begin
            if (push[ch]) begin
                mem_d[ch][wp_q[ch]] = in;
                wp_d[ch]            = ~wp_q[ch];
            end
            if (pop[ch]) begin
                rp_d[ch] = ~rp_q[ch];
            end
            cnt_d[ch] = cnt_q[ch] + {1'b0, push[ch]} - {1'b0, pop[ch]};
        end
    end

    // State registers; reset discards everything, including stored data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Head outputs, forced to zero when the channel is empty.
    always_comb begin
        out1_valid = out_valid[0];
        out2_valid = out_valid[1];
        out1       = out_valid[0] ? mem_q[0][rp_q[0]] : 4'b0000;
        out2       = out_valid[1] ? mem_q[1][rp_q[1]] : 4'b0000;
    end

endmodule

// File: tb/tb_demux1_2_4bit_buf.sv
// Directed testbench for demux1_2_4bit_buf: reset, routing, backpressure,
// simultaneous push/pop, wrap-around ordering, select change under stall.
module tb_demux1_2_4bit_buf;

    logic       clk;
    logic       rst_n;
    logic [3:0] in;
    logic       in_valid;
    logic       s;
    logic       in_ready;
    logic [3:0] out1;
    logic       out1_valid;
    logic       out1_ready;
    logic [3:0] out2;
    logic       out2_valid;
    logic       out2_ready;

    int n_cmp;
    int n_err;

    demux1_2_4bit_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in),
        .in_valid   (in_valid),
        .s          (s),
        .in_ready   (in_ready),
        .out1       (out1),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2       (out2),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One rising edge; returns at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in         = 4'h0;
        s          = 1'b0;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
    endtask

    task automatic push_word(input logic sel, input logic [3:0] d);
        s        = sel;
        in       = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int next_in;
        int exp_out;
        int budget;
        logic will_push;
        logic will_pop;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();

        // Reset state
        chk("rst_out1", {4'h0, out1}, 8'h00);
        chk("rst_v1", {7'h0, out1_valid}, 8'h00);
        chk("rst_out2", {4'h0, out2}, 8'h00);
        chk("rst_v2", {7'h0, out2_valid}, 8'h00);
        s = 1'b1; #1;
        chk("rst_rdy_s1", {7'h0, in_ready}, 8'h01);
        s = 1'b0; #1;
        chk("rst_rdy_s0", {7'h0, in_ready}, 8'h01);
        rst_n = 1'b1;
        tick();

        // Routing
        push_word(1'b1, 4'hA);
        chk("route_out1", {4'h0, out1}, 8'h0A);
        chk("route_v1", {7'h0, out1_valid}, 8'h01);
        chk("route_v2_empty", {7'h0, out2_valid}, 8'h00);
        push_word(1'b0, 4'h5);
        chk("route_out2", {4'h0, out2}, 8'h05);
        chk("route_v2", {7'h0, out2_valid}, 8'h01);
        chk("route_out1_kept", {4'h0, out1}, 8'h0A);
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        tick();
        chk("route_drain_v1", {7'h0, out1_valid}, 8'h00);
        chk("route_drain_v2", {7'h0, out2_valid}, 8'h00);
        chk("route_drain_out1", {4'h0, out1}, 8'h00);
        idle_inputs();

        // Full / backpressure on channel 1
        push_word(1'b1, 4'h3);
        push_word(1'b1, 4'h7);
        s = 1'b1; in = 4'h9; in_valid = 1'b1; #1;
        chk("full_rdy_s1", {7'h0, in_ready}, 8'h00);
        chk("full_head", {4'h0, out1}, 8'h03);
        s = 1'b0; #1;
        chk("full_rdy_s0", {7'h0, in_ready}, 8'h01);
        s = 1'b1; #1;
        out1_ready = 1'b1;
        tick();
        chk("full_pop_head", {4'h0, out1}, 8'h07);
        #1;
        chk("full_cnt1_rdy", {7'h0, in_ready}, 8'h01);
        out1_ready = 1'b0;
        tick();
        in_valid = 1'b0; #1;
        chk("full_again_rdy", {7'h0, in_ready}, 8'h00);
        chk("full_head_still7", {4'h0, out1}, 8'h07);
        out1_ready = 1'b1;
        tick();
        chk("full_drain_9", {4'h0, out1}, 8'h09);
        tick();
        chk("full_drain_empty", {7'h0, out1_valid}, 8'h00);
        chk("full_drain_zero", {4'h0, out1}, 8'h00);
        chk("full_ch2_untouched", {7'h0, out2_valid}, 8'h00);
        idle_inputs();

        // Simultaneous push and pop on channel 2
        push_word(1'b0, 4'hC);
        chk("sim_head_c", {4'h0, out2}, 8'h0C);
        s = 1'b0; in = 4'hD; in_valid = 1'b1; out2_ready = 1'b1;
        tick();
        in_valid = 1'b0; out2_ready = 1'b0;
        chk("sim_head_d", {4'h0, out2}, 8'h0D);
        chk("sim_v2", {7'h0, out2_valid}, 8'h01);
        out2_ready = 1'b1;
        tick();
        chk("sim_cnt_was1", {7'h0, out2_valid}, 8'h00);
        idle_inputs();

        // Wrap-around: 0..F through channel 1 with random consumer stalls
        next_in = 0;
        exp_out = 0;
        budget  = 0;
        while (exp_out < 16 && budget < 400) begin
            if (!out1_valid) chk("wrap_gate", {4'h0, out1}, 8'h00);
            s          = 1'b1;
            in_valid   = (next_in < 16);
            in         = 4'(next_in);
            out1_ready = 1'($urandom_range(0, 1));
            #1;
            will_push = in_valid && in_ready;
            will_pop  = out1_valid && out1_ready;
            if (will_pop) begin
                chk("wrap_order", {4'h0, out1}, 8'(exp_out));
                exp_out++;
            end
            tick();
            if (will_push) next_in++;
            budget++;
        end
        chk("wrap_count", 8'(exp_out), 8'd16);
        chk("wrap_ch2_untouched", {7'h0, out2_valid}, 8'h00);
        idle_inputs();
        tick();

        // Select change while channel 1 is full and the word is stalled
        push_word(1'b1, 4'h1);
        push_word(1'b1, 4'h2);
        s = 1'b1; in = 4'hE; in_valid = 1'b1; #1;
        chk("sel_stall_rdy", {7'h0, in_ready}, 8'h00);
        s = 1'b0; #1;
        chk("sel_switch_rdy", {7'h0, in_ready}, 8'h01);
        tick();
        in_valid = 1'b0;
        chk("sel_out2_e", {4'h0, out2}, 8'h0E);
        chk("sel_v2", {7'h0, out2_valid}, 8'h01);
        chk("sel_out1_head", {4'h0, out1}, 8'h01);
        out1_ready = 1'b1;
        tick();
        chk("sel_out1_next", {4'h0, out1}, 8'h02);
        tick();
        chk("sel_ch1_empty", {7'h0, out1_valid}, 8'h00);
        chk("sel_ch2_kept", {4'h0, out2}, 8'h0E);
        out2_ready = 1'b1;
        tick();
        chk("sel_ch2_empty", {7'h0, out2_valid}, 8'h00);
        idle_inputs();

        // Asynchronous reset mid-stream with count1=2, count2=1
        push_word(1'b1, 4'h4);
        push_word(1'b1, 4'h6);
        push_word(1'b0, 4'h8);
        s = 1'b1; in = 4'hF; in_valid = 1'b1; #2;
        rst_n = 1'b0; #1;
        chk("mrst_out1", {4'h0, out1}, 8'h00);
        chk("mrst_v1", {7'h0, out1_valid}, 8'h00);
        chk("mrst_out2", {4'h0, out2}, 8'h00);
        chk("mrst_v2", {7'h0, out2_valid}, 8'h00);
        chk("mrst_rdy_s1", {7'h0, in_ready}, 8'h01);
        s = 1'b0; #1;
        chk("mrst_rdy_s0", {7'h0, in_ready}, 8'h01);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("mrst_rel_v1", {7'h0, out1_valid}, 8'h00);
        chk("mrst_rel_v2", {7'h0, out2_valid}, 8'h00);
        s = 1'b1; #1;
        chk("mrst_rel_rdy", {7'h0, in_ready}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux1_2_4bit_buf.md
# demux1_2_4bit_buf

Buffered 1-to-2 demultiplexer for 4-bit words: a single input stream with valid/ready handshake is routed by `s` to one of two output channels. Each channel has its own 2-entry FIFO and valid/ready handshake. It is the distribution-side counterpart of the 2:1 4-bit multiplexer, with the same select convention: `s=1` means channel 1 and `s=0` means channel 2. It splits a shared datapath back onto two consumers that drain independently.

## Interface
- No parameters: data width fixed at 4, per-channel depth fixed at 2.
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  asynchronous active-low reset
- in  input  4  input data word
- in_valid  input  1  input word present
- s  input  1  route select: 1 = out1 channel, 0 = out2 channel; sampled with in/in_valid
- in_ready  output  1  selected channel can accept this cycle (combinational)
- out1  output  4  channel-1 head data; 4'b0000 when channel 1 empty
- out1_valid  output  1  channel 1 non-empty
- out1_ready  input  1  channel-1 consumer accepts head
- out2  output  4  channel-2 head data; 4'b0000 when channel 2 empty
- out2_valid  output  1  channel 2 non-empty
- out2_ready  input  1  channel-2 consumer accepts head

## Operation
- **Per-channel state:**
  - two 4-bit entries;
  - 1-bit write pointer `wp`;
  - 1-bit read pointer `rp`;
  - 2-bit `count` holding 0, 1 or 2.
  - Both channels are identical and independent.
- **Ready:** `in_ready` = (s ? count1 : count2) != 2.
  - It is a pure function of `s` and the registered counts.
  - It does not depend on `out*_ready`, so a full channel never accepts, even when it pops in the same cycle.
  - `in_ready` does not depend on `in_valid`.
- **Push:**
  - Occurs when `in_valid && in_ready` at a clock edge.
  - `in` is written into the selected channel's entry[wp], then wp toggles and count increments.
  - The unselected channel is untouched.
- **Pop (channel k):**
  - Occurs when `outk_valid && outk_ready` at a clock edge.
  - rp toggles and count decrements.
  - `outk_ready` while empty has no effect.
- **Simultaneous push and pop on the same channel:** both happen, count is unchanged, and FIFO order is preserved.
  - count=1 → the new word becomes the head after the edge.
  - count=2 cannot occur, because push is blocked.
- **Outputs:**
  - `outk_valid` = (countk != 0).
  - `outk` = `outk_valid` ? entry[rp] : 4'b0000 (AND-gated, mirroring the mux gating).
- **Wrap-around:** pointers are 1 bit and toggle freely; order is strictly FIFO per channel across any number of wraps.
- **Select changes:**
  - `s` may change on any cycle, including while `in_valid` is held and `in_ready` is low.
  - `in_ready` follows the new `s` combinationally.
  - No word is routed on a cycle without a handshake.
- **Ordering:** there is no ordering guarantee between channels; each consumer drains independently.
- **Reset (`rst_n` low, any time, asynchronous):**
  - all counts = 0, all pointers = 0, all entries = 4'b0000;
  - hence out1 = out2 = 4'b0000 and out1_valid = out2_valid = 0;
  - in_ready = 1 for either `s`;
  - words buffered or in flight are discarded, and no partial push survives.
  - Deassertion takes effect on the first rising edge with `rst_n` high.

## Timing
- Latency: a word pushed at edge N appears on `outk` with `outk_valid`=1 immediately after edge N, so it is consumable at edge N+1.
- Throughput: one word per cycle into a channel, provided its consumer pops every cycle (count stays ≤1).
- With a stalled consumer, a channel accepts exactly 2 words, then `in_ready`=0 for that `s` until a pop edge.
- All state changes on the rising edge of `clk` except reset.
- Combinational paths:
  - `s`/counts → `in_ready`;
  - rp/entries/counts → `outk`.
- There is no combinational path from in*/out*_ready to out*.

## Test plan
- **Reset:** hold rst_n=0 mid-stream with count1=2 and count2=1, then release → out1=out2=0, both valids 0, in_ready=1 for s=0 and s=1.
- **Routing:**
  - Stimulus: push 4'hA with s=1, then 4'h5 with s=0; no pops.
  - Response: after the first edge out1=A and out1_valid=1; after the second edge out2=5 and out2_valid=1; out1 still A.
- **Full/backpressure:**
  - Stimulus: s=1, out1_ready=0, push 3, 7, then hold 9 valid.
  - Response: in_ready=0 after two pushes; with s=0, in_ready=1 at the same time.
  - Then assert out1_ready for one edge → out1 changes 3→7 and count1=1; 9 is accepted on the next edge, and the drain order is 3, 7, 9.
- **Simultaneous push/pop:**
  - Stimulus: count2=1 holding C; on one edge push D with s=0 and out2_ready=1.
  - Response: out2=D and count2=1 after the edge.
- **Wrap-around:** stream 16 words 0..F into channel 1 with out1_ready toggling randomly → output order 0..F with no loss or duplication; out1=0 whenever out1_valid=0.
- **Select change under stall:** channel 1 full, in_valid=1 with data E, s switches 1→0 → in_ready rises the same cycle; E lands in channel 2 only, and channel 1 contents are unchanged.
